// File: rtl/dsm_pkg.sv
// Shared constants, ternary code points and the integrator saturation helper
// for the second-order ternary delta-sigma modulator.
package dsm_pkg;
  localparam int IN_W    = 11;
  localparam int ACC_W   = 16;
  localparam int FS      = 1 << (IN_W - 1);
  localparam int THR_HI  = 512;
  localparam int THR_LO  = -512;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));

  localparam logic [1:0] PWM_POS  = 2'b01;
  localparam logic [1:0] PWM_ZERO = 2'b00;
  localparam logic [1:0] PWM_NEG  = 2'b11;

  // Clamp a wide signed sum into the integrator range; wrapping would
  // lock the loop up after an overload.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [31:0] x);
    if (x > ACC_MAX) return ACC_W'(ACC_MAX);
    else if (x < ACC_MIN) return ACC_W'(ACC_MIN);
    return x[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/dsm_if.sv
// Sample-in / ternary-code-out bundle; no handshake, everything moves every clock.
interface dsm_if import dsm_pkg::*; ();
  logic signed [IN_W-1:0] vin;
  logic signed [IN_W-1:0] dith_i;
  logic        [1:0]      pwm;

  modport master (output vin, output dith_i, input pwm);
  modport slave  (input vin, input dith_i, output pwm);
endinterface

// File: rtl/dsm_quant3.sv
// Combinational 3-level quantizer: y -> feedback value and ternary output code.
module dsm_quant3 import dsm_pkg::*; (
  input  logic signed [ACC_W:0]   y,
  output logic signed [ACC_W-1:0] fb,
  output logic        [1:0]       code
);
  logic signed [1:0] q;

  always_comb begin
    q = 2'sb00;
    if (y >= THR_HI)     q = 2'sb01;
    else if (y < THR_LO) q = 2'sb11;
  end

  always_comb begin
    fb   = '0;
    code = PWM_ZERO;
    case (q)
      2'sb01:  begin fb = ACC_W'(FS);  code = PWM_POS; end
      2'sb11:  begin fb = -ACC_W'(FS); code = PWM_NEG; end
      default: begin fb = '0;          code = PWM_ZERO; end
    endcase
  end
endmodule

// File: rtl/dsm_top.sv
// Second-order delta-sigma modulator: two saturating integrators around a
// ternary quantizer, both integrators fed back with the same q*FS value.
module dsm_top import dsm_pkg::*; (
  input logic clock,
  input logic reset,
  dsm_if.slave bus
);
  logic signed [ACC_W-1:0] i1, i2, i1n, i2n, fb;
  logic signed [ACC_W:0]   y;
  logic        [1:0]       code, pwm;

  assign y = (ACC_W+1)'(i2) + (ACC_W+1)'(bus.dith_i);

  dsm_quant3 u_quant (
    .y    (y),
    .fb   (fb),
    .code (code)
  );

  // The second integrator sees the already-updated first one (i1n), which
  // is what gives the (1 - z^-1)^2 noise transfer.
  always_comb begin
    i1n = sat(32'(i1) + 32'(bus.vin) - 32'(fb));
    i2n = sat(32'(i2) + 32'(i1n) - 32'(fb));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i1  <= '0;
      i2  <= '0;
      pwm <= PWM_ZERO;
    end else begin
      i1  <= i1n;
      i2  <= i2n;
      pwm <= code;
    end
  end

  assign bus.pwm = pwm;
endmodule

// File: tb/tb_dsm_top.sv
// Random and directed stimulus for dsm_top, checked every cycle against an
// integer model of the modulator plus long-run mean and literal checks.
`timescale 1ns/1ps
module tb_dsm_top;
  import dsm_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  dsm_if bus ();

  dsm_top u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int bad10  = 0;

  // reference model state (plain integers)
  int m_i1 = 0, m_i2 = 0, m_q = 0, m_y = 0, m_fb = 0;
  int seq512[6] = '{0, 1, 0, 0, 1, 1};

  function automatic int clampi(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic logic [1:0] code_of(input int q);
    if (q > 0) return 2'b01;
    if (q < 0) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int dec(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real lo, input real hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %f want [%f,%f]", name, act, lo, hi);
    end
  endtask

  // Model advances on each rising edge from the inputs in effect, then the
  // DUT output and integrators are compared just after the edge.
  always @(posedge clock) begin
    if (reset) begin
      m_i1 = 0; m_i2 = 0; m_q = 0;
    end else begin
      m_y  = m_i2 + int'(bus.dith_i);
      m_q  = (m_y >= 512) ? 1 : ((m_y < -512) ? -1 : 0);
      m_fb = m_q * 1024;
      m_i1 = clampi(m_i1 + int'(bus.vin) - m_fb);
      m_i2 = clampi(m_i2 + m_i1 - m_fb);
    end
    #1;
    checks++;
    if (bus.pwm !== code_of(m_q)) begin
      errors++;
      $display("FAIL cyc_pwm t=%0t got %b want %b", $time, bus.pwm, code_of(m_q));
    end
    checks++;
    if (int'(u_dut.i1) != m_i1 || int'(u_dut.i2) != m_i2) begin
      errors++;
      $display("FAIL cyc_integ t=%0t got %0d/%0d want %0d/%0d",
               $time, u_dut.i1, u_dut.i2, m_i1, m_i2);
    end
  end

  // Drive one cycle of inputs at the falling edge, return the code produced
  // by the following rising edge.
  task automatic step(input int v, input int d, input bit r, output logic [1:0] c);
    @(negedge clock);
    bus.vin    = IN_W'(v);
    bus.dith_i = IN_W'(d);
    reset      = r;
    @(posedge clock);
    #2;
    c = bus.pwm;
    if (c == 2'b10) bad10++;
  endtask

  task automatic measure(input int v, input int d, input int n, input int skip, output real mean);
    logic [1:0] c;
    int sum = 0;
    for (int i = 0; i < n; i++) begin
      step(v, d, 1'b0, c);
      if (i >= skip) sum += dec(c);
    end
    mean = real'(sum) / real'(n - skip);
  endtask

  initial begin
    logic [1:0] c;
    real m;
    int nz;
    int pw[$];
    int vv[$];
    bus.vin    = '0;
    bus.dith_i = '0;
    reset      = 1'b1;

    // reset held with most-negative input, then first outputs after release
    for (int i = 0; i < 5; i++) begin
      step(-1024, 0, 1'b1, c);
      chk("rst_pwm", int'(c), 0);
    end
    step(-1024, 0, 1'b0, c);
    chk("first_pwm", int'(c), 0);
    chk("model_i1_first", m_i1, -1024);
    step(-1024, 0, 1'b0, c);
    chk("second_pwm", int'(c), 3);

    // hand-traced start-up for vin=+512: q = 0,1,0,0,1,1
    step(512, 0, 1'b1, c);
    for (int i = 0; i < 6; i++) begin
      step(512, 0, 1'b0, c);
      chk("seq512", int'(c), int'(code_of(seq512[i])));
    end

    // idle input stays silent
    step(0, 0, 1'b1, c);
    nz = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 0, 1'b0, c);
      if (c != 2'b00) nz++;
    end
    chk("zero_nonzero_codes", nz, 0);

    measure(512, 0, 2048, 32, m);
    chk_real("mean_p512", m, 0.495, 0.505);
    chk("code10_seen", bad10, 0);

    measure(-768, 0, 2048, 32, m);
    chk_real("mean_n768", m, -0.755, -0.745);

    // overload then recovery
    for (int i = 0; i < 500; i++) step(1023, 0, 1'b0, c);
    measure(0, 0, 1152, 128, m);
    chk_real("mean_recover", m, -0.01, 0.01);

    measure(0, 300, 2048, 32, m);
    chk_real("mean_dither", m, -0.005, 0.005);

    // sine with a one-cycle reset mid-stream
    for (int k = 0; k < 1536; k++) begin
      int v;
      v = $rtoi(700.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0));
      step(v, 0, (k == 700), c);
      if (k == 700) chk("sine_rst_pwm", int'(c), 0);
      if (k >= 900) begin
        pw.push_back(dec(c));
        vv.push_back(v);
      end
    end
    for (int w = 0; w < 8; w++) begin
      int sp = 0, sv = 0;
      for (int j = 0; j < 128; j++) begin
        sp += pw[w*64 + j];
        sv += vv[w*64 + j];
      end
      chk_real("sine_track", real'(sp) / 128.0 - real'(sv) / (128.0 * 1024.0), -0.1, 0.1);
    end

    // random inputs, dither and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int v, d;
      v = int'($urandom_range(1536, 0)) - 768;
      d = int'($urandom_range(511, 0)) - 256;
      step(v, d, ($urandom_range(199, 0) == 0), c);
    end
    chk("code10_final", bad10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
